seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_hex_decoder.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan controller.
// Segment patterns are polarity-free ({g,f,e,d,c,b,a}, 1 = lit).
package seg7_pkg;

  typedef enum logic [1:0] {
    OFF,
    DEAD,
    ON
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to 7-segment pattern, combinational.
// Output is polarity-free; the top applies display polarity.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller with tear-free value buffering.
// Define SEG7_LZ_BLANK_EN to enable leading-zero blanking.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int CLK_DIV     = 50000,
  parameter int DEAD_CYCLES = 4,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  output logic        ready,
  output logic [1:0]  digit_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CntLast  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DeadLast = CW'(DEAD_CYCLES - 1);
  localparam logic [6:0] SegMask = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;

  scan_state_t state, stateNext;
  logic [CW-1:0] slotCnt, slotCntNext;
  logic [1:0] digitSel, digitSelNext;
  logic commit;

  logic pendValid;
  logic [15:0] pendVal, dispReg, dispNext;
  logic [3:0] pendDp, dispDp, dispDpNext;

  logic [3:0] nibble;
  logic [6:0] rawSeg;
  logic blank, lit;
  logic [3:0] anNext;
  logic [6:0] segNext;
  logic dpNext;

  logic [3:0] anQ;
  logic [6:0] segQ;
  logic dpQ, frameQ;

  // Scan state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= OFF;
      slotCnt  <= '0;
      digitSel <= '0;
    end else begin
      state    <= stateNext;
      slotCnt  <= slotCntNext;
      digitSel <= digitSelNext;
    end
  end

  // Next scan state, slot position and commit points
  always_comb begin
    stateNext    = state;
    slotCntNext  = slotCnt;
    digitSelNext = digitSel;
    commit       = 1'b0;
    if (!en) begin
      stateNext    = OFF;
      slotCntNext  = '0;
      digitSelNext = '0;
    end else begin
      unique case (state)
        OFF: begin
          stateNext    = DEAD;
          slotCntNext  = '0;
          digitSelNext = '0;
          commit       = 1'b1;
        end
        DEAD: begin
          slotCntNext = slotCnt + 1'b1;
          if (slotCnt == DeadLast) stateNext = ON;
        end
        ON: begin
          if (slotCnt == CntLast) begin
            slotCntNext  = '0;
            stateNext    = DEAD;
            digitSelNext = digitSel + 2'd1;
            commit       = (digitSel == 2'd3);
          end else begin
            slotCntNext = slotCnt + 1'b1;
          end
        end
        default: stateNext = OFF;
      endcase
    end
  end

  assign dispNext   = (commit && pendValid) ? pendVal : dispReg;
  assign dispDpNext = (commit && pendValid) ? pendDp : dispDp;
  assign nibble     = dispNext[{digitSelNext, 2'b00} +: 4];

  seg7_hex_decoder uDec (
    .nibble  (nibble),
    .pattern (rawSeg)
  );

`ifdef SEG7_LZ_BLANK_EN
  assign blank = (digitSelNext != 2'd0)
              && !dispDpNext[digitSelNext]
              && ((dispNext >> {digitSelNext, 2'b00}) == 16'h0);
`else
  assign blank = 1'b0;
`endif

  assign lit = (stateNext == ON) && !blank;

  // Next output pattern, computed from next state so it aligns with it
  always_comb begin
    anNext  = 4'hF;
    segNext = SEG_OFF ^ SegMask;
    dpNext  = SegMask[0];
    if (lit) begin
      anNext  = ~(4'b0001 << digitSelNext);
      segNext = rawSeg ^ SegMask;
      dpNext  = dispDpNext[digitSelNext] ^ SegMask[0];
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anQ    <= 4'hF;
      segQ   <= SEG_OFF ^ SegMask;
      dpQ    <= SegMask[0];
      frameQ <= 1'b0;
    end else begin
      anQ    <= anNext;
      segQ   <= segNext;
      dpQ    <= dpNext;
      frameQ <= commit;
    end
  end

  // Pending buffer and displayed value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pendValid <= 1'b0;
      pendVal   <= '0;
      pendDp    <= '0;
      dispReg   <= '0;
      dispDp    <= '0;
    end else begin
      dispReg <= dispNext;
      dispDp  <= dispDpNext;
      if (load && !pendValid) begin
        pendValid <= 1'b1;
        pendVal   <= value;
        pendDp    <= dp_mask;
      end else if (commit) begin
        pendValid <= 1'b0;
      end
    end
  end

  assign ready     = ~pendValid;
  assign digit_sel = digitSel;
  assign an        = anQ;
  assign seg       = segQ;
  assign dp        = dpQ;
  assign frame     = frameQ;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl against a frame-position model.
// Honours SEG7_LZ_BLANK_EN in the model when it is defined.
module tb_seg7_scan_ctrl;

  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0] dp_mask = '0;
  logic ready;
  logic [1:0] digit_sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic dp;
  logic frame;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .CLK_DIV     (DIV),
    .DEAD_CYCLES (DEAD),
    .SEG_ACT_LOW (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .load      (load),
    .value     (value),
    .dp_mask   (dp_mask),
    .ready     (ready),
    .digit_sel (digit_sel),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame     (frame)
  );

  logic [6:0] hexTab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: position within the running frame
  bit mOn = 0;
  int mP = 0;
  bit mPv = 0;
  bit mFrame = 0;
  logic [15:0] mPend = '0, mDisp = '0;
  logic [3:0] mPendDp = '0, mDispDp = '0;

  task automatic modelStep();
    bit cm;
    bit pvOld;
    if (!rst_n) begin
      mOn = 0; mP = 0; mPv = 0; mFrame = 0;
      mPend = '0; mDisp = '0; mPendDp = '0; mDispDp = '0;
      return;
    end
    cm = 0;
    pvOld = mPv;
    if (!en) mOn = 0;
    else if (!mOn) begin
      mOn = 1; mP = 0; cm = 1;
    end else begin
      mP = (mP + 1) % FRAME;
      cm = (mP == 0);
    end
    mFrame = cm;
    if (cm && pvOld) begin
      mDisp = mPend; mDispDp = mPendDp; mPv = 0;
    end
    if (load && !pvOld) begin
      mPend = value; mPendDp = dp_mask; mPv = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int digit, w;
    bit lit, blank;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic expDp;
    logic [15:0] upper;
    digit = mP / DIV;
    w = mP % DIV;
    upper = mDisp >> (4 * digit);
    blank = 0;
`ifdef SEG7_LZ_BLANK_EN
    blank = (digit != 0) && !mDispDp[digit] && (upper == 0);
`endif
    lit = mOn && (w >= DEAD) && !blank;
    expAn = lit ? ~(4'b0001 << digit) : 4'hF;
    expSeg = lit ? ~hexTab[upper[3:0]] : 7'h7F;
    expDp = lit ? ~mDispDp[digit] : 1'b1;
    chk("an", 16'(an), 16'(expAn));
    chk("seg", 16'(seg), 16'(expSeg));
    chk("dp", 16'(dp), 16'(expDp));
    chk("digit_sel", 16'(digit_sel), mOn ? 16'(digit) : 16'h0);
    chk("ready", 16'(ready), 16'(!mPv));
    chk("frame", 16'(frame), 16'(mFrame));
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  task automatic runUntil(input int d, input bit inOn);
    bit met;
    met = 0;
    for (int i = 0; i < 100; i++) begin
      if (mOn && (mP / DIV == d) && ((mP % DIV >= DEAD) == inOn)) begin
        met = 1;
        break;
      end
      cycle();
    end
    chk("wait_timeout", 16'(met), 16'h1);
  endtask

  initial begin
    // Reset
    repeat (3) cycle();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);
    chk("rst_ready", 16'(ready), 16'h1);
    chk("rst_sel", 16'(digit_sel), 16'h0);
    rst_n = 1'b1;

    // Scan order with 4321
    load = 1'b1; value = 16'h4321; dp_mask = 4'h0;
    cycle();
    load = 1'b0;
    en = 1'b1;
    cycle();
    chk("first_frame", 16'(frame), 16'h1);
    cycle();
    chk("dead_an", 16'(an), 16'hF);
    cycle();
    chk("d0_an", 16'(an), 16'hE);
    chk("d0_seg", 16'(seg), 16'h79);
    repeat (FRAME - 3) cycle();

    // Handshake: second load while not ready is dropped
    runUntil(1, 1);
    load = 1'b1; value = 16'hAAAA;
    cycle();
    chk("hs_ready0", 16'(ready), 16'h0);
    value = 16'hBBBB;
    cycle();
    load = 1'b0;
    repeat (FRAME + 8) cycle();

    // Enable drop during digit 2 ON
    runUntil(2, 1);
    en = 1'b0;
    cycle();
    chk("drop_an", 16'(an), 16'hF);
    chk("drop_sel", 16'(digit_sel), 16'h0);
    en = 1'b1;
    cycle();
    chk("restart_frame", 16'(frame), 16'h1);
    repeat (FRAME) cycle();

    // Leading-zero pattern, then with dp on digit 3
    load = 1'b1; value = 16'h0050; dp_mask = 4'h0;
    cycle();
    load = 1'b0;
    repeat (2 * FRAME) cycle();
    load = 1'b1; dp_mask = 4'b1000;
    cycle();
    load = 1'b0;
    repeat (2 * FRAME) cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 3) == 0);
      value = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                          : 16'($urandom_range(0, 255));
      dp_mask = 4'($urandom);
      en = ($urandom_range(0, 63) != 0);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end
    rst_n = 1'b1; en = 1'b1; load = 1'b0;

    // Reset mid-ON of digit 3 with a pending value
    runUntil(0, 1);
    load = 1'b1; value = 16'h1234; dp_mask = 4'h5;
    cycle();
    load = 1'b0;
    runUntil(3, 1);
    rst_n = 1'b0;
    cycle();
    chk("mid_rst_an", 16'(an), 16'hF);
    chk("mid_rst_ready", 16'(ready), 16'h1);
    chk("mid_rst_sel", 16'(digit_sel), 16'h0);
    rst_n = 1'b1;
    repeat (FRAME + 4) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
